sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Hardware draw engine for the CHIP-8/SCHIP draw instruction (DXYN). On command from `cpu` it fetches sprite bytes from `ram`, then XORs each set bit into `vram` via read-modify-write. It reports pixel collision for VF. It sits between the CPU execute stage and the `ram`/`vram` ports, and is the only writer of `vram` while `busy` is high.

## Interface
Parameters:
- `CLIP`, default 1: 1 = pixels past the right/bottom edge are dropped; 0 = they wrap mod 128 / mod 64.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  draw request; sampled only in IDLE
- `x`  in  8  sprite X origin (used mod 128)
- `y`  in  8  sprite Y origin (used mod 64)
- `n`  in  4  row count; 0 = 16×16 SCHIP sprite
- `i_addr`  in  12  sprite data base address
- `plane`  in  2  plane mask XORed into each drawn pixel
- `busy`  out  1  high while a draw is in progress
- `done`  out  1  one-cycle pulse at draw end
- `collision`  out  1  set if any drawn pixel had `(pixelo & plane) != 0` before the XOR; held until next accepted start
- `ram_addr`  out  12  sprite byte address
- `ram_dout`  in  8  read data, valid one cycle after `ram_addr`
- `vram_hpos`  out  7  pixel column
- `vram_vpos`  out  6  pixel row
- `vram_pixelo`  in  2  read pixel, valid one cycle after `hpos`/`vpos`
- `vram_pixeli`  out  2  write pixel
- `vram_we`  out  1  write strobe, committed at posedge

## Operation
- States: IDLE, FETCH, LOAD, SCAN, READ, WRITE, DONE.
- IDLE: on `start`=1, latch `x[6:0]`, `y[5:0]`, `n`, `i_addr`, `plane`.
  - rows = (n==0) ? 16 : n; bytes_per_row = (n==0) ? 2 : 1.
  - Clear `collision`, clear the byte index, go to FETCH.
- FETCH: drive `ram_addr` = i + byte_index (12-bit wrap). Go to LOAD.
- LOAD: capture `ram_dout` into the shift register, column = 0, go to SCAN.
- SCAN: one cycle per bit, MSB first.
  - Pixel column = (x + 8·(byte_index mod bytes_per_row) + column) mod 128; pixel row = (y + row) mod 64.
  - If the bit is 1, `plane`≠0, and the pixel is on-screen, go to READ.
  - CLIP=1: a pixel is off-screen when the unwrapped x+offset ≥ 128 or y+row ≥ 64. CLIP=0: every pixel is on-screen.
  - Otherwise advance the column. After column 7, advance byte_index: to FETCH if bytes remain, else to DONE.
- READ: drive `vram_hpos`/`vram_vpos`, then go to WRITE.
- WRITE: keep the same address.
  - `vram_pixeli` = `vram_pixelo` ^ `plane`, `vram_we`=1.
  - If `(vram_pixelo & plane) != 0`, set `collision`.
  - Return to the SCAN successor of the current column.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` during `busy` is ignored; there is no queueing.
- `plane`=0: bytes are still fetched and timing is unchanged, but no vram access occurs and `collision` stays 0.

## Timing
- Reset (`reset`=0 at posedge): state IDLE. `busy`, `done`, `collision`, `vram_we`, `ram_addr`, `vram_hpos`, `vram_vpos`, `vram_pixeli` all reset to 0. This applies mid-draw too; the partial image stays in vram.
- All outputs are registered except `vram_pixeli`, which is combinational from `vram_pixelo` in WRITE only.
- `busy` rises the cycle after `start` is accepted (cycle 0) and falls with `done`.
- `done` asserts at cycle 1 + 10·bytes + 2·drawn, where bytes = rows·bytes_per_row and drawn = pixels that enter READ.
- `vram_we` is high only in WRITE, never on two consecutive cycles.
- `ram_addr` is stable from FETCH through LOAD.
- `collision` is valid no later than the `done` cycle.

## Test plan
- n=1, byte 0x80 at i=0x200, x=0, y=0, plane=01, vram clear → one write at (0,0) with pixeli=01; `done` at cycle 13; `collision`=0.
- Repeat the same draw → pixel (0,0) returns to 00, `collision`=1.
- x=126, y=63, n=2, bytes 0xFF,0xFF, CLIP=1 → only (126,63) and (127,63) written; row 2 dropped; `done` at cycle 1+20+4=25. Same with CLIP=0 → 16 writes, wrapping to columns 0–5 and to row 0.
- n=0, 32 bytes 0xFF at i=0xFF0 → `ram_addr` wraps 0xFFF→0x000; 256 writes over a 16×16 area; `done` at cycle 1+320+512=833.
- `reset` low for one cycle mid-SCAN → next cycle IDLE with all outputs 0; new `start` draws normally.
- `start` pulsed while busy, and plane=00 draw → second start ignored; plane=00 gives zero `vram_we` and `collision`=0.

Source files
------------

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - CHIP-8/SCHIP DXYN sprite draw engine (fetch, XOR into vram, collision)
module sprite_blitter #(
  parameter int CLIP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  input  logic [1:0]  plane,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixelo,
  output logic [1:0]  vram_pixeli,
  output logic        vram_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [6:0]  r_x;
  logic [5:0]  r_y;
  logic [11:0] r_i;
  logic [1:0]  r_plane;
  logic        r_bpr2;
  logic [5:0]  r_total;
  logic [5:0]  r_byte_idx;
  logic [7:0]  r_shift;
  logic [2:0]  r_col;
  logic        r_busy;
  logic        r_done;
  logic        r_collision;
  logic [11:0] r_ram_addr;
  logic [6:0]  r_hpos;
  logic [5:0]  r_vpos;
  logic        r_we;

  logic        w_half;
  logic [3:0]  w_row;
  logic [7:0]  w_xsum;
  logic [6:0]  w_ysum;
  logic        w_onscreen;
  logic        w_draw;
  logic [5:0]  w_byte_inc;
  state_t      w_adv_state;
  logic        w_accept;
  logic        w_advance;
  logic        w_unused_bits;

  assign w_unused_bits = ^{x[7], y[7:6]};

  // Two-byte-wide SCHIP rows: even byte is the left half, odd byte the right half.
  assign w_half     = r_bpr2 & r_byte_idx[0];
  assign w_row      = r_bpr2 ? r_byte_idx[4:1] : r_byte_idx[3:0];
  assign w_xsum     = {1'b0, r_x} + {4'b0000, w_half, 3'b000} + {5'b00000, r_col};
  assign w_ysum     = {1'b0, r_y} + {3'b000, w_row};
  assign w_onscreen = (CLIP == 0) || (!w_xsum[7] && !w_ysum[6]);
  assign w_draw     = r_shift[7] && (r_plane != 2'b00) && w_onscreen;
  assign w_byte_inc = r_byte_idx + 6'd1;

  always_comb begin
    w_adv_state = S_SCAN;
    if (r_col == 3'd7) begin
      w_adv_state = (w_byte_inc == r_total) ? S_DONE : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_SCAN;
      S_SCAN: begin
        if (w_draw) begin
          w_next = S_READ;
        end else begin
          w_advance = 1'b1;
          w_next    = w_adv_state;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        w_advance = 1'b1;
        w_next    = w_adv_state;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_i         <= '0;
      r_plane     <= '0;
      r_bpr2      <= 1'b0;
      r_total     <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_collision <= 1'b0;
      r_ram_addr  <= '0;
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_we        <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      r_we   <= (w_next == S_WRITE);
      if (w_accept) begin
        r_x         <= x[6:0];
        r_y         <= y[5:0];
        r_i         <= i_addr;
        r_plane     <= plane;
        r_bpr2      <= (n == 4'd0);
        r_total     <= (n == 4'd0) ? 6'd32 : {2'b00, n};
        r_byte_idx  <= '0;
        r_collision <= 1'b0;
      end
      if (w_next == S_FETCH) begin
        r_ram_addr <= w_accept ? i_addr : (r_i + {6'b000000, w_byte_inc});
      end
      if (r_state == S_LOAD) begin
        r_shift <= ram_dout;
        r_col   <= '0;
      end
      if (w_advance) begin
        r_col   <= r_col + 3'd1;
        r_shift <= {r_shift[6:0], 1'b0};
        if (r_col == 3'd7) begin
          r_byte_idx <= w_byte_inc;
        end
      end
      if (w_next == S_READ) begin
        r_hpos <= w_xsum[6:0];
        r_vpos <= w_ysum[5:0];
      end
      if ((r_state == S_WRITE) && ((vram_pixelo & r_plane) != 2'b00)) begin
        r_collision <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign collision   = r_collision;
  assign ram_addr    = r_ram_addr;
  assign vram_hpos   = r_hpos;
  assign vram_vpos   = r_vpos;
  assign vram_we     = r_we;
  assign vram_pixeli = (r_state == S_WRITE) ? (vram_pixelo ^ r_plane) : 2'b00;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed bench for sprite_blitter, clipped and wrapping instances
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  y = 8'd0;
  logic [3:0]  n = 4'd0;
  logic [11:0] i_addr = 12'd0;
  logic [1:0]  plane = 2'd0;

  logic        busy0, done0, col0, we0, busy1, done1, col1, we1;
  logic [11:0] ra0, ra1;
  logic [7:0]  rd0 = 8'd0, rd1 = 8'd0;
  logic [6:0]  h0, h1;
  logic [5:0]  v0, v1;
  logic [1:0]  po0 = 2'd0, po1 = 2'd0, pi0, pi1;

  logic [7:0]  ram [0:4095];
  logic [1:0]  vram0 [0:63][0:127];
  logic [1:0]  vram1 [0:63][0:127];
  logic        clr = 1'b0;
  logic [1:0]  clr_val = 2'd0;

  int checks = 0;
  int failures = 0;
  int dc0, dc1, wr0, wr1, consec0, consec1, cnt;
  logic col_at_done0, col_at_done1, busy_at1, saw_wrap, saw_busy;

  always #5 clk = ~clk;

  sprite_blitter #(.CLIP(1)) u_clip (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .n(n), .i_addr(i_addr),
    .plane(plane), .busy(busy0), .done(done0), .collision(col0), .ram_addr(ra0),
    .ram_dout(rd0), .vram_hpos(h0), .vram_vpos(v0), .vram_pixelo(po0),
    .vram_pixeli(pi0), .vram_we(we0)
  );

  sprite_blitter #(.CLIP(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .n(n), .i_addr(i_addr),
    .plane(plane), .busy(busy1), .done(done1), .collision(col1), .ram_addr(ra1),
    .ram_dout(rd1), .vram_hpos(h1), .vram_vpos(v1), .vram_pixelo(po1),
    .vram_pixeli(pi1), .vram_we(we1)
  );

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    rd0 <= ram[ra0];
    rd1 <= ram[ra1];
    if (clr) begin
      for (int r = 0; r < 64; r++) begin
        for (int c = 0; c < 128; c++) begin
          vram0[r][c] <= clr_val;
          vram1[r][c] <= clr_val;
        end
      end
    end else begin
      if (we0) vram0[v0][h0] <= pi0;
      if (we1) vram1[v1][h1] <= pi1;
    end
    po0 <= vram0[v0][h0];
    po1 <= vram1[v1][h1];
  end

  function automatic int count_px(input logic sel);
    int k = 0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 128; c++) begin
        if ((sel ? vram1[r][c] : vram0[r][c]) != 2'd0) k++;
      end
    end
    return k;
  endfunction

  task automatic clear_vram(input logic [1:0] val);
    @(negedge clk);
    clr_val = val;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_draw(input logic [7:0] tx, input logic [7:0] ty, input logic [3:0] tn,
                          input logic [11:0] ta, input logic [1:0] tp, input int restart_at,
                          input int budget);
    int c;
    logic [11:0] last_ra;
    logic pw0, pw1;
    wr0 = 0; wr1 = 0; consec0 = 0; consec1 = 0; dc0 = -1; dc1 = -1;
    col_at_done0 = 1'bx; col_at_done1 = 1'bx; busy_at1 = 1'b0; saw_wrap = 1'b0;
    pw0 = 1'b0; pw1 = 1'b0; last_ra = ra0; c = 0;
    @(negedge clk);
    x = tx; y = ty; n = tn; i_addr = ta; plane = tp; start = 1'b1;
    while ((dc0 < 0 || dc1 < 0) && c < budget) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == restart_at) begin
        x = 8'd40; plane = 2'b10; start = 1'b1;
      end
      if (c == 1) busy_at1 = busy0;
      if (we0) begin wr0++; if (pw0) consec0++; end
      if (we1) begin wr1++; if (pw1) consec1++; end
      pw0 = we0; pw1 = we1;
      if (last_ra == 12'hFFF && ra0 == 12'h000) saw_wrap = 1'b1;
      last_ra = ra0;
      if (done0 && dc0 < 0) begin dc0 = c; col_at_done0 = col0; end
      if (done1 && dc1 < 0) begin dc1 = c; col_at_done1 = col1; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, col0, we0, ra0, h0, v0, pi0} !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs_clip got=%h exp=0", {busy0, done0, col0, we0, ra0, h0, v0, pi0});
    end
    checks++;
    if ({busy1, done1, col1, we1, ra1, h1, v1, pi1} !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs_wrap got=%h exp=0", {busy1, done1, col1, we1, ra1, h1, v1, pi1});
    end
    reset = 1'b1;
  endtask

  task automatic test_single_pixel;
    clear_vram(2'd0);
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, 2'b01, 0, 100);
    checks++; if (dc0 !== 13) begin failures++; $display("FAIL single_done_cycle got=%0d exp=13", dc0); end
    checks++; if (dc1 !== 13) begin failures++; $display("FAIL single_done_cycle_wrap got=%0d exp=13", dc1); end
    checks++; if (busy_at1 !== 1'b1) begin failures++; $display("FAIL single_busy_rise got=%0b exp=1", busy_at1); end
    checks++; if (wr0 !== 1) begin failures++; $display("FAIL single_writes got=%0d exp=1", wr0); end
    checks++; if (vram0[0][0] !== 2'b01) begin failures++; $display("FAIL single_pixel got=%0d exp=1", vram0[0][0]); end
    checks++; if (col_at_done0 !== 1'b0) begin failures++; $display("FAIL single_collision got=%0b exp=0", col_at_done0); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%0b exp=0", busy0); end
  endtask

  task automatic test_repeat;
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, 2'b01, 0, 100);
    checks++; if (dc0 !== 13) begin failures++; $display("FAIL repeat_done_cycle got=%0d exp=13", dc0); end
    checks++; if (vram0[0][0] !== 2'b00) begin failures++; $display("FAIL repeat_pixel got=%0d exp=0", vram0[0][0]); end
    checks++; if (col_at_done0 !== 1'b1) begin failures++; $display("FAIL repeat_collision got=%0b exp=1", col_at_done0); end
    repeat (3) @(negedge clk);
    checks++; if (col0 !== 1'b1) begin failures++; $display("FAIL repeat_collision_held got=%0b exp=1", col0); end
  endtask

  task automatic test_clip_wrap;
    clear_vram(2'd0);
    run_draw(8'd126, 8'd63, 4'd2, 12'h300, 2'b01, 0, 200);
    checks++; if (dc0 !== 25) begin failures++; $display("FAIL clip_done_cycle got=%0d exp=25", dc0); end
    checks++; if (wr0 !== 2) begin failures++; $display("FAIL clip_writes got=%0d exp=2", wr0); end
    checks++;
    if ({vram0[63][126], vram0[63][127], vram0[0][0]} !== 6'b010100) begin
      failures++;
      $display("FAIL clip_pixels got=%b exp=010100", {vram0[63][126], vram0[63][127], vram0[0][0]});
    end
    cnt = count_px(1'b0);
    checks++; if (cnt !== 2) begin failures++; $display("FAIL clip_pixel_count got=%0d exp=2", cnt); end
    checks++; if (dc1 !== 53) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=53", dc1); end
    checks++; if (wr1 !== 16) begin failures++; $display("FAIL wrap_writes got=%0d exp=16", wr1); end
    cnt = count_px(1'b1);
    checks++; if (cnt !== 16) begin failures++; $display("FAIL wrap_pixel_count got=%0d exp=16", cnt); end
    checks++;
    if ({vram1[0][5], vram1[0][6], vram1[63][0], vram1[0][127]} !== 8'b01000101) begin
      failures++;
      $display("FAIL wrap_pixels got=%b exp=01000101", {vram1[0][5], vram1[0][6], vram1[63][0], vram1[0][127]});
    end
    checks++; if ((consec0 + consec1) !== 0) begin failures++; $display("FAIL clip_we_consecutive got=%0d exp=0", consec0 + consec1); end
  endtask

  task automatic test_schip;
    clear_vram(2'd0);
    run_draw(8'd0, 8'd0, 4'd0, 12'hFF0, 2'b01, 0, 1200);
    checks++; if (dc0 !== 833) begin failures++; $display("FAIL schip_done_cycle got=%0d exp=833", dc0); end
    checks++; if (wr0 !== 256) begin failures++; $display("FAIL schip_writes got=%0d exp=256", wr0); end
    checks++; if (saw_wrap !== 1'b1) begin failures++; $display("FAIL schip_addr_wrap got=%0b exp=1", saw_wrap); end
    cnt = count_px(1'b0);
    checks++; if (cnt !== 256) begin failures++; $display("FAIL schip_pixel_count got=%0d exp=256", cnt); end
    checks++;
    if ({vram0[15][15], vram0[15][16], vram0[16][15]} !== 6'b010000) begin
      failures++;
      $display("FAIL schip_corner got=%b exp=010000", {vram0[15][15], vram0[15][16], vram0[16][15]});
    end
    checks++; if (consec0 !== 0) begin failures++; $display("FAIL schip_we_consecutive got=%0d exp=0", consec0); end
  endtask

  task automatic test_reset_mid;
    clear_vram(2'd0);
    @(negedge clk);
    x = 8'd0; y = 8'd0; n = 4'd1; i_addr = 12'h400; plane = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, done0, col0, we0, ra0, h0, v0, pi0} !== 31'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {busy0, done0, col0, we0, ra0, h0, v0, pi0});
    end
    reset = 1'b1;
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, 2'b01, 0, 100);
    checks++; if (dc0 !== 13) begin failures++; $display("FAIL midreset_redraw_cycle got=%0d exp=13", dc0); end
    checks++;
    if ({vram0[0][0], vram0[0][7]} !== 4'b0100) begin
      failures++;
      $display("FAIL midreset_pixels got=%b exp=0100", {vram0[0][0], vram0[0][7]});
    end
  endtask

  task automatic test_back_to_back;
    clear_vram(2'd0);
    run_draw(8'd0, 8'd0, 4'd1, 12'h200, 2'b01, 4, 100);
    checks++; if (dc0 !== 13) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=13", dc0); end
    checks++; if (wr0 !== 1) begin failures++; $display("FAIL b2b_writes got=%0d exp=1", wr0); end
    checks++;
    if ({vram0[0][0], vram0[0][40]} !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_pixels got=%b exp=0100", {vram0[0][0], vram0[0][40]});
    end
    saw_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy0) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL b2b_no_second_draw got=%0b exp=0", saw_busy); end
  endtask

  task automatic test_plane_zero;
    clear_vram(2'd3);
    run_draw(8'd0, 8'd0, 4'd1, 12'h300, 2'b00, 0, 100);
    checks++; if (dc0 !== 11) begin failures++; $display("FAIL plane0_done_cycle got=%0d exp=11", dc0); end
    checks++; if (wr0 !== 0) begin failures++; $display("FAIL plane0_writes got=%0d exp=0", wr0); end
    checks++; if (col_at_done0 !== 1'b0) begin failures++; $display("FAIL plane0_collision got=%0b exp=0", col_at_done0); end
    checks++; if (vram0[0][0] !== 2'd3) begin failures++; $display("FAIL plane0_pixel got=%0d exp=3", vram0[0][0]); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    ram[12'h200] = 8'h80;
    ram[12'h300] = 8'hFF;
    ram[12'h301] = 8'hFF;
    ram[12'h400] = 8'h01;
    for (int a = 0; a < 16; a++) begin
      ram[12'hFF0 + a] = 8'hFF;
      ram[a] = 8'hFF;
    end
    test_reset();
    test_single_pixel();
    test_repeat();
    test_clip_wrap();
    test_schip();
    test_reset_mid();
    test_back_to_back();
    test_plane_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
